list_walk_arbiter: RTL and testbench

Shared linked-list walker that arbitrates between two requesters. It owns the next-pointer table (one entry per node, pointer 0 is the null terminator) and a configuration write port that loads that table. Each accepted start pointer is traversed one node per cycle, and every output pointer is tagged with the requester that owns it. The block sits between the request generators and the pointer consumer, and replaces per-requester walkers with one time-shared table and walker.

---
 rtl/list_walk_arbiter.sv | 146 ++++++++++++++
 tb/tb_list_walk_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/list_walk_arbiter.sv
// Two-requester linked-list walker sharing one next-pointer table.
// Emits one node per cycle, tags each with its owner, and truncates runaway walks at N nodes.
module list_walk_arbiter #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_data,
  output logic         cfg_rdy,
  input  logic [W-1:0] req0_start,
  input  logic         req0_vld,
  output logic         req0_rdy,
  input  logic [W-1:0] req1_start,
  input  logic         req1_vld,
  output logic         req1_rdy,
  output logic [W-1:0] out_ptr,
  output logic         out_vld,
  output logic         out_id,
  output logic         out_last,
  output logic         out_err
);

  localparam int SW = $clog2(N + 1);

  typedef enum logic {IDLE = 1'b0, WALK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    out_ptr_q, out_ptr_d;
  logic            out_id_q, out_id_d;
  logic            out_vld_q, out_vld_d;
  logic [SW-1:0]   step_q, step_d;
  logic            rr_q, rr_d;
  logic [W-1:0]    tbl_q [N];
  logic [W-1:0]    tbl_d [N];

  logic [W-1:0]    next_ptr_s;
  logic            at_limit_s;
  logic            final_s;
  logic            window_s;
  logic            any_vld_s;
  logic            grant_s;
  logic            accept_s;
  logic [W-1:0]    start_s;

  // Table: configuration writes only land while no walk is in flight
  always_comb begin
    tbl_d = tbl_q;
    if (cfg_we && (state_q == IDLE)) begin
      tbl_d[cfg_addr] = cfg_data;
    end else begin
      tbl_d = tbl_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        tbl_q[i] <= {W{1'b0}};
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  // Arbitration: final-node cycle or config-free idle cycle opens the window
  always_comb begin
    next_ptr_s = tbl_q[out_ptr_q];
    at_limit_s = (step_q == SW'(N));
    final_s    = (state_q == WALK) && ((next_ptr_s == {W{1'b0}}) || at_limit_s);
    window_s   = ((state_q == IDLE) && !cfg_we) || final_s;
    any_vld_s  = req0_vld || req1_vld;
    if (req0_vld && req1_vld) begin
      grant_s = ~rr_q;
    end else begin
      grant_s = req1_vld;
    end
    accept_s = window_s && any_vld_s;
    start_s  = grant_s ? req1_start : req0_start;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      out_ptr_q <= {W{1'b0}};
      out_id_q  <= 1'b0;
      out_vld_q <= 1'b0;
      step_q    <= {SW{1'b0}};
      rr_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      out_ptr_q <= out_ptr_d;
      out_id_q  <= out_id_d;
      out_vld_q <= out_vld_d;
      step_q    <= step_d;
      rr_q      <= rr_d;
    end
  end

  // Next-state: new accept preempts the finishing walk, else advance or fall idle
  always_comb begin
    state_d   = state_q;
    out_ptr_d = out_ptr_q;
    out_id_d  = out_id_q;
    out_vld_d = 1'b0;
    step_d    = step_q;
    rr_d      = rr_q;
    if (accept_s) begin
      rr_d = grant_s;
      if (start_s != {W{1'b0}}) begin
        state_d   = WALK;
        out_ptr_d = start_s;
        out_id_d  = grant_s;
        out_vld_d = 1'b1;
        step_d    = SW'(1);
      end else begin
        state_d = IDLE;
        step_d  = {SW{1'b0}};
      end
    end else if ((state_q == WALK) && !final_s) begin
      state_d   = WALK;
      out_ptr_d = next_ptr_s;
      out_vld_d = 1'b1;
      step_d    = step_q + SW'(1);
    end else begin
      state_d = IDLE;
      step_d  = {SW{1'b0}};
    end
  end

  // Outputs
  always_comb begin
    out_ptr  = out_ptr_q;
    out_id   = out_id_q;
    out_vld  = out_vld_q;
    out_last = final_s;
    out_err  = final_s && at_limit_s && (next_ptr_s != {W{1'b0}});
    cfg_rdy  = (state_q == IDLE);
    req0_rdy = accept_s && !grant_s;
    req1_rdy = accept_s && grant_s;
  end

endmodule

// File: tb/tb_list_walk_arbiter.sv
// Bench for list_walk_arbiter: directed scenarios plus random traffic against a walk-list model.
module tb_list_walk_arbiter;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_we = 1'b0;
  logic [W-1:0] cfg_addr = '0;
  logic [W-1:0] cfg_data = '0;
  logic         cfg_rdy;
  logic [W-1:0] req0_start = '0;
  logic         req0_vld = 1'b0;
  logic         req0_rdy;
  logic [W-1:0] req1_start = '0;
  logic         req1_vld = 1'b0;
  logic         req1_rdy;
  logic [W-1:0] out_ptr;
  logic         out_vld;
  logic         out_id;
  logic         out_last;
  logic         out_err;

  list_walk_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_rdy(cfg_rdy),
    .req0_start(req0_start), .req0_vld(req0_vld), .req0_rdy(req0_rdy),
    .req1_start(req1_start), .req1_vld(req1_vld), .req1_rdy(req1_rdy),
    .out_ptr(out_ptr), .out_vld(out_vld), .out_id(out_id),
    .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] ptr;
    logic         id;
    logic         last;
    logic         err;
  } node_t;

  // Reference model: the table, the remaining nodes of the current walk, round-robin and held outputs
  logic [W-1:0] m_tbl [N];
  node_t        m_q[$];
  logic         m_rr;
  logic [W-1:0] m_hold_ptr;
  logic         m_hold_id;

  int ncmp = 0;
  int nfail = 0;
  int vld_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_tbl[i] = '0;
    m_q.delete();
    m_rr = 1'b1;
    m_hold_ptr = '0;
    m_hold_id = 1'b0;
  endtask

  // Whole walk of a list from the model table, truncated after N nodes
  task automatic enqueue_walk(input logic [W-1:0] start, input logic id);
    logic [W-1:0] p;
    node_t n;
    p = start;
    for (int k = 1; k <= N; k++) begin
      n.ptr = p;
      n.id = id;
      n.last = (m_tbl[p] == '0) || (k == N);
      n.err = (k == N) && (m_tbl[p] != '0);
      m_q.push_back(n);
      if (n.last) break;
      p = m_tbl[p];
    end
  endtask

  // One cycle: compare at the falling edge with current inputs, advance model, wait past rising edge
  task automatic step();
    logic busy, window, any, grant, acc;
    logic [W-1:0] st;
    @(negedge clk);
    busy = (m_q.size() > 0);
    if (busy) begin
      m_hold_ptr = m_q[0].ptr;
      m_hold_id = m_q[0].id;
    end
    chk("out_vld", out_vld, busy);
    chk("out_ptr", out_ptr, m_hold_ptr);
    chk("out_id", out_id, m_hold_id);
    chk("out_last", out_last, busy ? m_q[0].last : 1'b0);
    chk("out_err", out_err, busy ? m_q[0].err : 1'b0);
    chk("cfg_rdy", cfg_rdy, !busy);
    if (out_vld) vld_cnt++;
    if (out_err) err_cnt++;
    window = (!busy && !cfg_we) || (m_q.size() == 1);
    any = req0_vld || req1_vld;
    grant = (req0_vld && req1_vld) ? ~m_rr : req1_vld;
    acc = window && any && !rst;
    chk("req0_rdy", req0_rdy, window && any && !grant);
    chk("req1_rdy", req1_rdy, window && any && grant);
    st = grant ? req1_start : req0_start;
    if (!rst) begin
      if (busy) void'(m_q.pop_front());
      else if (cfg_we) m_tbl[cfg_addr] = cfg_data;
      if (acc) begin
        m_rr = grant;
        if (st != '0) enqueue_walk(st, grant);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [W-1:0] a, input logic [W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic req(input logic id, input logic [W-1:0] s);
    if (id) begin req1_vld = 1'b1; req1_start = s; end
    else begin req0_vld = 1'b1; req0_start = s; end
    step();
    req0_vld = 1'b0; req1_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Basic walk 7 -> 15 -> 8
    cfg(4'd7, 4'd15); cfg(4'd15, 4'd8); cfg(4'd8, 4'd0);
    req(1'b0, 4'd7);
    idle(4);

    // Fairness with both requesters holding valid
    cfg(4'd1, 4'd5); cfg(4'd5, 4'd0); cfg(4'd2, 4'd0);
    req0_vld = 1'b1; req0_start = 4'd1;
    req1_vld = 1'b1; req1_start = 4'd2;
    idle(8);
    req0_vld = 1'b0; req1_vld = 1'b0;
    idle(3);

    // Null then single-node list
    cfg(4'd6, 4'd0);
    req(1'b1, 4'd0);
    idle(1);
    req(1'b1, 4'd6);
    idle(2);

    // Cycle guard on a 3 <-> 5 loop
    cfg(4'd3, 4'd5); cfg(4'd5, 4'd3);
    vld_cnt = 0; err_cnt = 0;
    req(1'b0, 4'd3);
    idle(18);
    chk("guard_outputs", vld_cnt, 16);
    chk("guard_errs", err_cnt, 1);

    // Config during walk is dropped; in idle it wins over a request
    req(1'b0, 4'd7);
    cfg(4'd15, 4'd3);
    idle(3);
    req0_vld = 1'b1; req0_start = 4'd7;
    cfg(4'd15, 4'd2);
    idle(1);
    req0_vld = 1'b0;
    idle(4);

    // Asynchronous reset during node 15
    req(1'b0, 4'd7);
    step();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_out_ptr", out_ptr, 4'd0);
    model_reset();
    step();
    rst = 1'b0;
    req(1'b0, 4'd7);
    idle(3);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_addr = W'($urandom_range(0, N - 1));
      cfg_data = ($urandom_range(0, 2) == 0) ? 4'd0 : W'($urandom_range(0, N - 1));
      req0_vld = ($urandom_range(0, 2) == 0);
      req1_vld = ($urandom_range(0, 2) == 0);
      req0_start = W'($urandom_range(0, N - 1));
      req1_start = W'($urandom_range(0, N - 1));
      step();
    end
    cfg_we = 1'b0; req0_vld = 1'b0; req1_vld = 1'b0;
    idle(N + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
